// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared types for the ctr_n_updown counter family
//
// Purpose: run-mode and run-state enumerations used by ctr_n_updown and
//          anything that decodes its MODE input.
// Ports:   none (package).
package ctr_pkg;

  typedef enum logic [1:0] {
    CTR_FREE     = 2'd0,
    CTR_PERIODIC = 2'd1,
    CTR_ONESHOT  = 2'd2,
    CTR_RSVD     = 2'd3
  } ctr_mode_t;

  typedef enum logic {
    CTR_RUN  = 1'b0,
    CTR_HALT = 1'b1
  } ctr_state_t;

endpackage

// File: rtl/ctr_tick_gen.sv
// rtl/ctr_tick_gen.sv - CK strobe qualifier (rising-edge detect or level enable)
//
// Purpose: turns an asynchronous-ish strobe into a one-MasterClock tick.
//          CK_EDGE=1: tick on the first clk cycle ck is seen high after low.
//          CK_EDGE=0: tick on every clk cycle ck is high.
// Ports:
//   clk   input   system clock
//   rst   input   asynchronous active-high reset
//   ck    input   raw strobe
//   tick  output  qualified tick (combinational, same cycle as ck rises)
module ctr_tick_gen #(
  parameter bit CK_EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ck,
  output logic tick
);

  logic ck_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_q <= 1'b0;
    end else begin
      ck_q <= ck;
    end
  end

  // The tick is taken from the live ck against its registered copy, so the
  // edge detector costs no extra cycle of latency.
  assign tick = CK_EDGE ? (ck & ~ck_q) : ck;

endmodule

// File: rtl/ctr_n_updown.sv
// rtl/ctr_n_updown.sv - parametrised loadable up/down counter with run modes
//
// Purpose: WIDTH-bit cascadable counter with reload register, free/periodic/
//          one-shot modes, combinational ripple carry and registered TC pulse.
// Optional: define CTR_CAPTURE_EN to add the CAPT/CAPQ snapshot register.
// Ports:
//   CAPT         input   snapshot strobe (CTR_CAPTURE_EN only)
//   CAPQ         output  snapshot of Q (CTR_CAPTURE_EN only)
//   MasterClock  input   system clock
//   RESET        input   asynchronous active-high reset
//   CK           input   count/load strobe, qualified by CK_EDGE
//   D            input   parallel load data
//   LDL          input   active-low synchronous load
//   ENAB         input   count enable / carry-in
//   UP           input   1 = up, 0 = down
//   MODE         input   0 free, 1 periodic, 2 one-shot, 3 free
//   Q / QL       output  count value and its complement
//   CY           output  combinational carry/borrow-out
//   TC           output  registered one-cycle terminal-count pulse
//   DONE         output  one-shot expired flag
module ctr_n_updown
  import ctr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit CK_EDGE = 1'b1
) (
`ifdef CTR_CAPTURE_EN
  input  logic             CAPT,
  output logic [WIDTH-1:0] CAPQ,
`endif
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic             CK,
  input  logic [WIDTH-1:0] D,
  input  logic             LDL,
  input  logic             ENAB,
  input  logic             UP,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QL,
  output logic             CY,
  output logic             TC,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  ctr_state_t       state_q, state_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             term;
  ctr_mode_t        mode;

  ctr_tick_gen #(.CK_EDGE(CK_EDGE)) u_tick (
    .clk  (MasterClock),
    .rst  (RESET),
    .ck   (CK),
    .tick (tick)
  );

  assign mode = ctr_mode_t'(MODE);
  assign term = UP ? (q_q == '1) : (q_q == '0);

  always_ff @(posedge MasterClock or posedge RESET) begin
    if (RESET) begin
      q_q     <= '0;
      rld_q   <= '0;
      state_q <= CTR_RUN;
      tc_q    <= 1'b0;
    end else begin
      q_q     <= q_d;
      rld_q   <= rld_d;
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    q_d     = q_q;
    rld_d   = rld_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (tick) begin
      if (!LDL) begin
        q_d     = D;
        rld_d   = D;
        state_d = CTR_RUN;
      end else if (ENAB && (state_q == CTR_RUN)) begin
        if (!term) begin
          q_d = UP ? (q_q + ONE) : (q_q - ONE);
        end else begin
          tc_d = 1'b1;
          case (mode)
            CTR_PERIODIC: q_d = rld_q;
            CTR_ONESHOT:  state_d = CTR_HALT;
            // Free and reserved wrap to the opposite end.
            default:      q_d = UP ? '0 : '1;
          endcase
        end
      end
    end
  end

`ifdef CTR_CAPTURE_EN
  logic [WIDTH-1:0] capq_q;

  // Snapshot is independent of tick so software gets a coherent read of Q.
  always_ff @(posedge MasterClock or posedge RESET) begin
    if (RESET) begin
      capq_q <= '0;
    end else if (CAPT) begin
      capq_q <= q_q;
    end
  end

  assign CAPQ = capq_q;
`endif

  assign Q    = q_q;
  assign QL   = ~q_q;
  assign TC   = tc_q;
  // DONE is simply the halted state; a load or reset is the only way out.
  assign DONE = (state_q == CTR_HALT);
  assign CY   = ENAB & term & (state_q == CTR_RUN);

endmodule
